// File: rtl/flash_read_fsm.sv
// Flash-side responder: takes a word address from the audio counter over a 4-phase
// handshake, performs one Avalon-MM read of the flash and returns the word.
module flash_read_fsm #(
  parameter int unsigned ADDR_W         = 23,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk50M,
  input  logic              reset,
  input  logic              addr_ready_flag,
  input  logic [ADDR_W-1:0] current_address,
  output logic [DATA_W-1:0] flash_data,
  output logic              read_addr_start,
  output logic              read_error,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic              flash_mem_waitrequest,
  input  logic              flash_mem_readdatavalid,
  input  logic [DATA_W-1:0] flash_mem_readdata
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic [TW-1:0]          timer;
  logic                   req_s;
  logic                   accepted;
  logic                   capture;

  assign flash_mem_byteenable = 4'hF;
  assign req_s    = sync[SYNC_STAGES-1];
  assign accepted = (state == S_REQ) && !flash_mem_waitrequest;
  // Data counts only once the read has been accepted (same-cycle accept+data allowed).
  assign capture  = flash_mem_readdatavalid && (accepted || (state == S_WAIT));

  always_ff @(posedge clk50M) begin
    if (reset) begin
      state             <= S_IDLE;
      sync              <= '0;
      timer             <= '0;
      flash_data        <= '0;
      read_addr_start   <= 1'b0;
      read_error        <= 1'b0;
      flash_mem_read    <= 1'b0;
      flash_mem_address <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], addr_ready_flag};
      case (state)
        S_IDLE: begin
          read_addr_start <= 1'b0;
          if (req_s) begin
            flash_mem_address <= current_address;
            flash_mem_read    <= 1'b1;
            read_error        <= 1'b0;
            timer             <= '0;
            state             <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          if (accepted) flash_mem_read <= 1'b0;
          if (capture) begin
            flash_data      <= flash_mem_readdata;
            read_addr_start <= 1'b1;
            state           <= S_DONE;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            flash_mem_read  <= 1'b0;
            flash_data      <= '0;
            read_error      <= 1'b1;
            read_addr_start <= 1'b1;
            state           <= S_DONE;
          end else begin
            timer <= timer + TW'(1);
            if (accepted) state <= S_WAIT;
          end
        end
        S_DONE: begin
          if (!req_s) begin
            read_addr_start <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
